// File: rtl/cdb_arbiter.sv
// Round-robin arbiter packing up to N_LANE of N_REQ writeback results onto the CDB lanes.
// Latency: 1 cycle, grant in t -> registered broadcast in t+1. Optional CDB_ARB_PERF_EN adds stall counters.
// Backpressure: req_ready is combinational from req_valid/rr_ptr; losers and flushed requesters hold.
module cdb_arbiter #(
    parameter int N_REQ     = 6,
    parameter int N_LANE    = 4,
    parameter int PAYLOAD_W = 64
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 flush,
    input  logic [N_REQ-1:0]                     req_valid,
    input  logic [N_REQ*PAYLOAD_W-1:0]           req_payload,
    output logic [N_REQ-1:0]                     req_ready,
    output logic [N_LANE-1:0]                    cdb_valid,
    output logic [N_LANE*PAYLOAD_W-1:0]          cdb_payload,
    output logic [N_LANE*$clog2(N_REQ)-1:0]      cdb_src
`ifdef CDB_ARB_PERF_EN
    ,
    output logic [N_REQ*32-1:0]                  perf_stall_cnt
`endif
);

    localparam int SRC_W  = (N_REQ  > 1) ? $clog2(N_REQ)  : 1;
    localparam int LIDX_W = (N_LANE > 1) ? $clog2(N_LANE) : 1;

    logic [SRC_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [N_REQ-1:0]     grant;
    logic [N_LANE-1:0]    lane_vld;
    logic [SRC_W-1:0]     lane_src [N_LANE];
    logic [PAYLOAD_W-1:0] lane_pay [N_LANE];
    logic [PAYLOAD_W-1:0] req_pay  [N_REQ];

    logic [N_LANE-1:0]    cdb_valid_q;
    logic [SRC_W-1:0]     cdb_src_q [N_LANE];
    logic [PAYLOAD_W-1:0] cdb_pay_q [N_LANE];

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            req_pay[i] = req_payload[i*PAYLOAD_W +: PAYLOAD_W];
        end
    end

    // Scan from rr_ptr with modulo-N_REQ wrap; the n-th winner lands on lane n.
    always_comb begin
        int idx;
        int n_grant;
        int last_idx;
        grant    = '0;
        lane_vld = '0;
        for (int k = 0; k < N_LANE; k++) begin
            lane_src[k] = '0;
            lane_pay[k] = '0;
        end
        n_grant  = 0;
        last_idx = int'(rr_ptr_q);
        idx      = 0;
        for (int off = 0; off < N_REQ; off++) begin
            idx = int'(rr_ptr_q) + off;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!flush && req_valid[SRC_W'(idx)] && (n_grant < N_LANE)) begin
                grant[SRC_W'(idx)]         = 1'b1;
                lane_vld[LIDX_W'(n_grant)] = 1'b1;
                lane_src[LIDX_W'(n_grant)] = SRC_W'(idx);
                lane_pay[LIDX_W'(n_grant)] = req_pay[SRC_W'(idx)];
                last_idx                   = idx;
                n_grant                    = n_grant + 1;
            end
        end
        rr_ptr_d = rr_ptr_q;
        if (n_grant != 0) begin
            rr_ptr_d = (last_idx == N_REQ - 1) ? '0 : SRC_W'(last_idx + 1);
        end
    end

    assign req_ready = grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            cdb_valid_q <= '0;
            for (int k = 0; k < N_LANE; k++) begin
                cdb_src_q[k] <= '0;
                cdb_pay_q[k] <= '0;
            end
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= lane_vld;
            // Idle lanes keep stale src/payload; consumers qualify with cdb_valid.
            for (int k = 0; k < N_LANE; k++) begin
                if (lane_vld[k]) begin
                    cdb_src_q[k] <= lane_src[k];
                    cdb_pay_q[k] <= lane_pay[k];
                end
            end
        end
    end

    always_comb begin
        cdb_valid = cdb_valid_q;
        for (int k = 0; k < N_LANE; k++) begin
            cdb_src[k*SRC_W +: SRC_W]         = cdb_src_q[k];
            cdb_payload[k*PAYLOAD_W +: PAYLOAD_W] = cdb_pay_q[k];
        end
    end

`ifdef CDB_ARB_PERF_EN
    logic [31:0] stall_cnt_q [N_REQ];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_REQ; i++) begin
                stall_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req_valid[i] && !grant[i] && !flush && (stall_cnt_q[i] != 32'hFFFF_FFFF)) begin
                    stall_cnt_q[i] <= stall_cnt_q[i] + 32'd1;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            perf_stall_cnt[i*32 +: 32] = stall_cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, under/over-subscription, wrap, flush, optional stall counters.
module tb_cdb_arbiter;

    localparam int NR = 6;
    localparam int NL = 4;
    localparam int PW = 64;
    localparam int SW = 3;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               flush;
    logic [NR-1:0]      req_valid;
    logic [NR*PW-1:0]   req_payload;
    logic [NR-1:0]      req_ready;
    logic [NL-1:0]      cdb_valid;
    logic [NL*PW-1:0]   cdb_payload;
    logic [NL*SW-1:0]   cdb_src;
`ifdef CDB_ARB_PERF_EN
    logic [NR*32-1:0]   perf_stall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cdb_arbiter #(.N_REQ(NR), .N_LANE(NL), .PAYLOAD_W(PW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_payload(req_payload),
        .req_ready  (req_ready),
        .cdb_valid  (cdb_valid),
        .cdb_payload(cdb_payload),
        .cdb_src    (cdb_src)
`ifdef CDB_ARB_PERF_EN
        ,
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    function automatic logic [PW-1:0] pay(int i);
        return {32'hC0DE_0000 + 32'(i), 32'h5A5A_0000 + 32'(i * 7)};
    endfunction

    task automatic test_reset;
        rst_n     = 1'b0;
        flush     = 1'b0;
        req_valid = '0;
        for (int i = 0; i < NR; i++) req_payload[i*PW +: PW] = pay(i);
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (cdb_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_valid: got %b want 0000", cdb_valid); end
        n_checks++;
        if (cdb_src !== '0) begin n_fail++; $display("FAIL reset_src: got %h want 0", cdb_src); end
        n_checks++;
        if (cdb_payload !== '0) begin n_fail++; $display("FAIL reset_payload: got %h want 0", cdb_payload); end
        #1 rst_n = 1'b1;
        req_valid = '1;
        #1;
        n_checks++;
        if (req_ready !== 6'b001111) begin n_fail++; $display("FAIL reset_first_scan: got %b want 001111", req_ready); end
        @(posedge clk); #1;
        n_checks++;
        if (cdb_valid !== 4'b1111) begin n_fail++; $display("FAIL burst_valid: got %b want 1111", cdb_valid); end
        n_checks++;
        if (req_ready !== 6'b110011) begin n_fail++; $display("FAIL burst_ready: got %b want 110011", req_ready); end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (cdb_valid !== 4'b0000) begin n_fail++; $display("FAIL async_reset_valid: got %b want 0000", cdb_valid); end
        n_checks++;
        if (cdb_src !== '0) begin n_fail++; $display("FAIL async_reset_src: got %h want 0", cdb_src); end
        n_checks++;
        if (req_ready !== 6'b001111) begin n_fail++; $display("FAIL async_reset_ptr: got %b want 001111", req_ready); end
        req_valid = '0;
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_under_subscribed;
        int exp_src [4];
        @(posedge clk); #2 req_valid = 6'b000101;
        #1;
        n_checks++;
        if (req_ready !== 6'b000101) begin n_fail++; $display("FAIL under_ready: got %b want 000101", req_ready); end
        @(posedge clk); #1;
        n_checks++;
        if (cdb_valid !== 4'b0011) begin n_fail++; $display("FAIL under_valid: got %b want 0011", cdb_valid); end
        exp_src = '{0, 2, 0, 0};
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (cdb_src[k*SW +: SW] !== 3'(exp_src[k])) begin
                n_fail++; $display("FAIL under_src lane%0d: got %0d want %0d", k, cdb_src[k*SW +: SW], exp_src[k]);
            end
            n_checks++;
            if (cdb_payload[k*PW +: PW] !== pay(exp_src[k])) begin
                n_fail++; $display("FAIL under_pay lane%0d: got %h want %h", k, cdb_payload[k*PW +: PW], pay(exp_src[k]));
            end
        end
        #1 req_valid = '1;
        #1;
        n_checks++;
        if (req_ready !== 6'b111001) begin n_fail++; $display("FAIL under_next_ptr: got %b want 111001", req_ready); end
        @(posedge clk); #1;
        exp_src = '{3, 4, 5, 0};
        n_checks++;
        if (cdb_valid !== 4'b1111) begin n_fail++; $display("FAIL rot_valid: got %b want 1111", cdb_valid); end
        for (int k = 0; k < NL; k++) begin
            n_checks++;
            if (cdb_src[k*SW +: SW] !== 3'(exp_src[k])) begin
                n_fail++; $display("FAIL rot_src lane%0d: got %0d want %0d", k, cdb_src[k*SW +: SW], exp_src[k]);
            end
        end
        #1 req_valid = '0;
        @(posedge clk); #1;
        n_checks++;
        if (cdb_valid !== 4'b0000) begin n_fail++; $display("FAIL one_cycle_hold: got %b want 0000", cdb_valid); end
    endtask

    task automatic test_over_subscribed;
        int exp_src [3][4];
        logic [NR-1:0] exp_rdy [3];
        exp_src = '{'{0, 1, 2, 3}, '{4, 5, 0, 1}, '{2, 3, 4, 5}};
        exp_rdy = '{6'b110011, 6'b111100, 6'b001111};
        #1 req_valid = 6'b100000;
        #1;
        n_checks++;
        if (req_ready !== 6'b100000) begin n_fail++; $display("FAIL over_align: got %b want 100000", req_ready); end
        @(posedge clk); #2 req_valid = '1;
        #1;
        n_checks++;
        if (req_ready !== 6'b001111) begin n_fail++; $display("FAIL over_c1_ready: got %b want 001111", req_ready); end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (cdb_valid !== 4'b1111) begin n_fail++; $display("FAIL over_valid c%0d: got %b want 1111", c, cdb_valid); end
            for (int k = 0; k < NL; k++) begin
                n_checks++;
                if (cdb_src[k*SW +: SW] !== 3'(exp_src[c][k])) begin
                    n_fail++; $display("FAIL over_src c%0d lane%0d: got %0d want %0d", c, k, cdb_src[k*SW +: SW], exp_src[c][k]);
                end
                n_checks++;
                if (cdb_payload[k*PW +: PW] !== pay(exp_src[c][k])) begin
                    n_fail++; $display("FAIL over_pay c%0d lane%0d: got %h want %h", c, k, cdb_payload[k*PW +: PW], pay(exp_src[c][k]));
                end
            end
            if (c < 2) begin
                n_checks++;
                if (req_ready !== exp_rdy[c]) begin n_fail++; $display("FAIL over_ready c%0d: got %b want %b", c, req_ready, exp_rdy[c]); end
            end
        end
        #1 req_valid = '0;
    endtask

    task automatic test_wrap;
        int exp_src [3];
        exp_src = '{5, 0, 1};
        #1 req_valid = 6'b010000;
        #1;
        n_checks++;
        if (req_ready !== 6'b010000) begin n_fail++; $display("FAIL wrap_align: got %b want 010000", req_ready); end
        @(posedge clk); #2 req_valid = 6'b100011;
        #1;
        n_checks++;
        if (req_ready !== 6'b100011) begin n_fail++; $display("FAIL wrap_ready: got %b want 100011", req_ready); end
        @(posedge clk); #1;
        n_checks++;
        if (cdb_valid !== 4'b0111) begin n_fail++; $display("FAIL wrap_valid: got %b want 0111", cdb_valid); end
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (cdb_src[k*SW +: SW] !== 3'(exp_src[k])) begin
                n_fail++; $display("FAIL wrap_src lane%0d: got %0d want %0d", k, cdb_src[k*SW +: SW], exp_src[k]);
            end
            n_checks++;
            if (cdb_payload[k*PW +: PW] !== pay(exp_src[k])) begin
                n_fail++; $display("FAIL wrap_pay lane%0d: got %h want %h", k, cdb_payload[k*PW +: PW], pay(exp_src[k]));
            end
        end
        #1 req_valid = '1;
        #1;
        n_checks++;
        if (req_ready !== 6'b111100) begin n_fail++; $display("FAIL wrap_ptr2: got %b want 111100", req_ready); end
        @(posedge clk); #1 req_valid = '0;
    endtask

    task automatic test_flush;
        int exp_src [4];
        exp_src = '{1, 2, 3, 4};
        @(posedge clk); #2 req_valid = 6'b000001;
        #1;
        n_checks++;
        if (req_ready !== 6'b000001) begin n_fail++; $display("FAIL flush_pre_ready: got %b want 000001", req_ready); end
        @(posedge clk); #2;
        flush     = 1'b1;
        req_valid = 6'b111110;
        #1;
        n_checks++;
        if (req_ready !== 6'b000000) begin n_fail++; $display("FAIL flush_ready: got %b want 000000", req_ready); end
        n_checks++;
        if (cdb_valid !== 4'b0001) begin n_fail++; $display("FAIL flush_prior_bcast: got %b want 0001", cdb_valid); end
        @(posedge clk); #1;
        n_checks++;
        if (cdb_valid !== 4'b0000) begin n_fail++; $display("FAIL flush_valid: got %b want 0000", cdb_valid); end
        @(posedge clk); #1;
        n_checks++;
        if (cdb_valid !== 4'b0000) begin n_fail++; $display("FAIL flush_valid2: got %b want 0000", cdb_valid); end
        #1 flush = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 6'b011110) begin n_fail++; $display("FAIL flush_resume_ready: got %b want 011110", req_ready); end
        @(posedge clk); #1;
        n_checks++;
        if (cdb_valid !== 4'b1111) begin n_fail++; $display("FAIL flush_resume_valid: got %b want 1111", cdb_valid); end
        for (int k = 0; k < NL; k++) begin
            n_checks++;
            if (cdb_src[k*SW +: SW] !== 3'(exp_src[k])) begin
                n_fail++; $display("FAIL flush_resume_src lane%0d: got %0d want %0d", k, cdb_src[k*SW +: SW], exp_src[k]);
            end
        end
        #1 req_valid = '0;
    endtask

`ifdef CDB_ARB_PERF_EN
    task automatic test_perf;
        int exp_cnt [6];
        exp_cnt = '{1, 1, 1, 1, 2, 2};
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < NR; i++) begin
            n_checks++;
            if (perf_stall_cnt[i*32 +: 32] !== 32'd0) begin
                n_fail++; $display("FAIL perf_reset req%0d: got %0d want 0", i, perf_stall_cnt[i*32 +: 32]);
            end
        end
        #1 rst_n = 1'b1;
        #1 req_valid = '1;
        repeat (3) @(posedge clk);
        #2 flush = 1'b1;
        @(posedge clk);
        #2 flush = 1'b0;
        @(posedge clk);
        #1 req_valid = '0;
        #1;
        for (int i = 0; i < NR; i++) begin
            n_checks++;
            if (perf_stall_cnt[i*32 +: 32] !== 32'(exp_cnt[i])) begin
                n_fail++; $display("FAIL perf_cnt req%0d: got %0d want %0d", i, perf_stall_cnt[i*32 +: 32], exp_cnt[i]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_under_subscribed();
        test_over_subscribed();
        test_wrap();
        test_flush();
`ifdef CDB_ARB_PERF_EN
        test_perf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
